// File: rtl/axistream_unpack.sv
// Width-reducing AXI-Stream adapter: each accepted NUM_PACK*DATA_WIDTH word is
// replayed as NUM_PACK beats of DATA_WIDTH bits, with src_tlast repeated on every beat.
module axistream_unpack #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_PACK   = 4,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             src_tvalid,
   output logic                             src_tready,
   input  logic [NUM_PACK*DATA_WIDTH-1:0]   src_tdata,
   input  logic                             src_tlast,
   output logic                             dest_tvalid,
   input  logic                             dest_tready,
   output logic [DATA_WIDTH-1:0]            dest_tdata,
   output logic                             dest_tlast
);

   localparam int unsigned CNT_W = $clog2(NUM_PACK);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_PACK - 1);

   logic [NUM_PACK*DATA_WIDTH-1:0] buf_q, buf_d;
   logic                           last_q, last_d;
   logic                           valid_q, valid_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;

   logic                  beat_xfer;
   logic                  final_xfer;
   logic                  word_xfer;
   logic [DATA_WIDTH-1:0] slice_w [NUM_PACK];
   logic [DATA_WIDTH-1:0] beat_w  [NUM_PACK];

   // beat_w[b] is the slice sent as output beat b, so the counter indexes it directly.
   for (genvar k = 0; k < NUM_PACK; k++) begin : g_slice
      assign slice_w[k] = buf_q[k*DATA_WIDTH +: DATA_WIDTH];
      if (BIG_ENDIAN) begin : g_be
         assign beat_w[k] = slice_w[NUM_PACK-1-k];
      end else begin : g_le
         assign beat_w[k] = slice_w[k];
      end
   end

   assign dest_tvalid = valid_q;
   assign dest_tdata  = beat_w[cnt_q];
   assign dest_tlast  = last_q;

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      buf_d      = buf_q;
      last_d     = last_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      beat_xfer  = valid_q && dest_tready;
      final_xfer = beat_xfer && (cnt_q == LAST_BEAT);
      // Ready is gated by rst so it reads 0 throughout reset, not only after the first edge.
      src_tready = rst && (!valid_q || final_xfer);
      word_xfer  = src_tvalid && src_tready;

      if (word_xfer) begin
         buf_d   = src_tdata;
         last_d  = src_tlast;
         valid_d = 1'b1;
         cnt_d   = '0;
      end else if (final_xfer) begin
         valid_d = 1'b0;
         cnt_d   = '0;
      end else if (beat_xfer) begin
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the data buffer is reset too, because dest_tdata/dest_tlast must read 0 while in reset.
         buf_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         buf_q   <= buf_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_axistream_unpack.sv
// Self-checking bench: one big-endian and one little-endian instance share stimulus;
// a queue-based scoreboard predicts every beat, valid and ready from the word-level rules.
module tb_axistream_unpack;

   localparam int DW = 8;
   localparam int NP = 4;
   localparam int WW = DW * NP;

   logic          clk = 1'b0;
   logic          rst;
   logic          src_tvalid;
   logic [WW-1:0] src_tdata;
   logic          src_tlast;
   logic          dest_tready;

   logic          be_src_tready, be_dest_tvalid, be_dest_tlast;
   logic [DW-1:0] be_dest_tdata;
   logic          le_src_tready, le_dest_tvalid, le_dest_tlast;
   logic [DW-1:0] le_dest_tdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axistream_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .rst(rst),
      .src_tvalid(src_tvalid), .src_tready(be_src_tready),
      .src_tdata(src_tdata), .src_tlast(src_tlast),
      .dest_tvalid(be_dest_tvalid), .dest_tready(dest_tready),
      .dest_tdata(be_dest_tdata), .dest_tlast(be_dest_tlast)
   );

   axistream_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .rst(rst),
      .src_tvalid(src_tvalid), .src_tready(le_src_tready),
      .src_tdata(src_tdata), .src_tlast(src_tlast),
      .dest_tvalid(le_dest_tvalid), .dest_tready(dest_tready),
      .dest_tdata(le_dest_tdata), .dest_tlast(le_dest_tlast)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t be_q[$];
   beat_t le_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         be_q.delete();
         le_q.delete();
      end else begin
         automatic logic exp_valid = (be_q.size() != 0);
         automatic logic exp_ready = (be_q.size() == 0) || (be_q.size() == 1 && dest_tready);
         check("mon_be_valid", be_dest_tvalid, exp_valid);
         check("mon_le_valid", le_dest_tvalid, exp_valid);
         check("mon_be_ready", be_src_tready, exp_ready);
         check("mon_le_ready", le_src_tready, exp_ready);
         if (exp_valid && dest_tready) begin
            check("mon_be_data", be_dest_tdata, be_q[0].data);
            check("mon_be_last", be_dest_tlast, be_q[0].last);
            check("mon_le_data", le_dest_tdata, le_q[0].data);
            check("mon_le_last", le_dest_tlast, le_q[0].last);
            void'(be_q.pop_front());
            void'(le_q.pop_front());
         end
         if (src_tvalid && exp_ready) begin
            for (int b = 0; b < NP; b++) begin
               be_q.push_back('{data: src_tdata[(NP-1-b)*DW +: DW], last: src_tlast});
               le_q.push_back('{data: src_tdata[b*DW +: DW], last: src_tlast});
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct {
      logic [WW-1:0] word;
      logic          last;
      logic [WW-1:0] exp_be;  // beat 0 in the most significant byte
      logic [WW-1:0] exp_le;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one word and returns at posedge+1 of the cycle its first beat is valid.
   task automatic send(input logic [WW-1:0] word, input logic last);
      logic acc;
      acc = 1'b0;
      src_tvalid = 1'b1;
      src_tdata  = word;
      src_tlast  = last;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = be_src_tready;
         tick();
      end
      src_tvalid = 1'b0;
      if (!acc) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic expect_beat(input string name, input logic [DW-1:0] be_d,
                              input logic [DW-1:0] le_d, input logic last);
      @(negedge clk);
      check({name, "_be_valid"}, be_dest_tvalid, 1'b1);
      check({name, "_be_data"}, be_dest_tdata, be_d);
      check({name, "_le_data"}, le_dest_tdata, le_d);
      check({name, "_be_last"}, be_dest_tlast, last);
      check({name, "_le_last"}, le_dest_tlast, last);
      tick();
   endtask

   initial begin
      logic acc;
      logic [WW-1:0] w;

      vecs[0] = '{word: 32'hA1B2C3D4, last: 1'b1, exp_be: 32'hA1B2C3D4, exp_le: 32'hD4C3B2A1};
      vecs[1] = '{word: 32'h00FF00FF, last: 1'b0, exp_be: 32'h00FF00FF, exp_le: 32'hFF00FF00};
      vecs[2] = '{word: 32'h12345678, last: 1'b1, exp_be: 32'h12345678, exp_le: 32'h78563412};
      vecs[3] = '{word: 32'h80000001, last: 1'b0, exp_be: 32'h80000001, exp_le: 32'h01000080};

      // Reset: inputs active, outputs must stay quiet.
      rst = 1'b0;
      src_tvalid = 1'b1;
      src_tdata = 32'hFFFFFFFF;
      src_tlast = 1'b1;
      dest_tready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("rst_valid", be_dest_tvalid, 1'b0);
      check("rst_ready", be_src_tready, 1'b0);
      check("rst_data", be_dest_tdata, 8'h00);
      check("rst_last", be_dest_tlast, 1'b0);
      src_tvalid = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rel_ready", be_src_tready, 1'b1);
      tick();

      // Slice order, both endiannesses, full-rate sink.
      for (int v = 0; v < 4; v++) begin
         send(vecs[v].word, vecs[v].last);
         for (int b = 0; b < NP; b++)
            expect_beat("vec", vecs[v].exp_be[(NP-1-b)*DW +: DW],
                        vecs[v].exp_le[(NP-1-b)*DW +: DW], vecs[v].last);
      end
      @(negedge clk);
      check("vec_empty", be_dest_tvalid, 1'b0);
      tick();

      // Back-to-back words with src_tvalid held high.
      src_tvalid = 1'b1;
      src_tdata = 32'h01020304;
      src_tlast = 1'b0;
      @(negedge clk);
      check("b2b_ready_empty", be_src_tready, 1'b1);
      tick();
      src_tdata = 32'h05060708;
      for (int b = 0; b < 2*NP; b++) begin
         @(negedge clk);
         check("b2b_valid", be_dest_tvalid, 1'b1);
         check("b2b_data", be_dest_tdata, DW'(b + 1));
         check("b2b_ready", be_src_tready, (b == NP-1) || (b == 2*NP-1));
         tick();
         if (b == NP-1) src_tvalid = 1'b0;
      end

      // Backpressure after the first beat.
      send(32'hCAFEBABE, 1'b0);
      expect_beat("bp0", 8'hCA, 8'hBE, 1'b0);
      dest_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_valid", be_dest_tvalid, 1'b1);
         check("bp_hold_data", be_dest_tdata, 8'hFE);
         check("bp_hold_le_data", le_dest_tdata, 8'hBA);
         check("bp_ready", be_src_tready, 1'b0);
         tick();
      end
      dest_tready = 1'b1;
      expect_beat("bp1", 8'hFE, 8'hBA, 1'b0);
      expect_beat("bp2", 8'hBA, 8'hFE, 1'b0);
      expect_beat("bp3", 8'hBE, 8'hCA, 1'b0);

      // Reset in mid-word: outputs clear without a clock edge, remaining beats dropped.
      send(32'hDEADBEEF, 1'b1);
      expect_beat("mr0", 8'hDE, 8'hEF, 1'b1);
      expect_beat("mr1", 8'hAD, 8'hBE, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      check("mr_valid_now", be_dest_tvalid, 1'b0);
      check("mr_ready_now", be_src_tready, 1'b0);
      check("mr_data_now", be_dest_tdata, 8'h00);
      check("mr_last_now", be_dest_tlast, 1'b0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("mr_rel_ready", be_src_tready, 1'b1);
      check("mr_rel_valid", be_dest_tvalid, 1'b0);
      tick();
      send(32'h11223344, 1'b0);
      expect_beat("mr_new0", 8'h11, 8'h44, 1'b0);
      expect_beat("mr_new1", 8'h22, 8'h33, 1'b0);
      expect_beat("mr_new2", 8'h33, 8'h22, 1'b0);
      expect_beat("mr_new3", 8'h44, 8'h11, 1'b0);

      // Random traffic; the scoreboard checks every cycle.
      src_tvalid = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acc = src_tvalid && be_src_tready;
         tick();
         if (!src_tvalid || acc) begin
            w = WW'($urandom);
            src_tvalid = ($urandom_range(0, 3) != 0);
            src_tdata  = w;
            src_tlast  = 1'($urandom_range(0, 1));
         end
         dest_tready = ($urandom_range(0, 9) < 7);
      end

      // Drain within a bounded number of cycles.
      src_tvalid = 1'b0;
      dest_tready = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge clk);
         acc = !be_dest_tvalid && !le_dest_tvalid;
         tick();
      end
      check("drain", acc, 1'b1);
      check("drain_queue", 64'(be_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axistream_unpack.md
AXISTREAM_UNPACK -- requirements
Module: axistream_unpack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width in bits of one output beat.
REQ-002 SHALL have parameter NUM_PACK, default 4, number of output beats per input word; legal range is 2 or more.
REQ-003 SHALL have parameter BIG_ENDIAN, default 1'b1, selecting slice output order.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port src_tvalid, input, 1 bit: input word valid.
REQ-007 SHALL have port src_tready, output, 1 bit: input word accepted.
REQ-008 SHALL have port src_tdata, input, NUM_PACK*DATA_WIDTH bits: packed word; slice k is bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-009 SHALL have port src_tlast, input, 1 bit: packet-end flag of the input word.
REQ-010 SHALL have port dest_tvalid, output, 1 bit: output beat valid.
REQ-011 SHALL have port dest_tready, input, 1 bit: downstream ready.
REQ-012 SHALL have port dest_tdata, output, DATA_WIDTH bits: output beat.
REQ-013 SHALL have port dest_tlast, output, 1 bit: packet-end flag of the output beat.

Function
REQ-014 An input transfer SHALL occur on a clock edge where src_tvalid && src_tready; an output transfer SHALL occur on an edge where dest_tvalid && dest_tready.
REQ-015 An input transfer SHALL capture all of src_tdata and src_tlast into a one-word buffer and set the beat counter to 0.
REQ-016 Each accepted word SHALL produce exactly NUM_PACK output transfers, then the buffer SHALL become empty.
REQ-017 Output transfer number b (0..NUM_PACK-1) SHALL carry slice NUM_PACK-1-b when BIG_ENDIAN=1, and slice b when BIG_ENDIAN=0.
REQ-018 dest_tlast SHALL equal the captured src_tlast on every one of the NUM_PACK beats of that word.
REQ-019 dest_tvalid SHALL be 1 exactly when the buffer holds a word; dest_tdata and dest_tlast SHALL be driven from the buffer and counter.
REQ-020 Latency: the first beat of a word SHALL be valid in the cycle after its input transfer.
REQ-021 src_tready SHALL be 1 when the buffer is empty, or when the final beat (counter = NUM_PACK-1) transfers in the same cycle; it SHALL be 0 otherwise.
REQ-022 Accepting a new word in the same cycle as the final-beat transfer SHALL give gapless back-to-back output.
REQ-023 When dest_tready=0 with dest_tvalid=1, dest_tdata, dest_tlast and the counter SHALL hold.
REQ-024 The beat counter SHALL wrap from NUM_PACK-1 to 0 and SHALL never leave the range 0..NUM_PACK-1.
REQ-025 Once dest_tvalid is asserted, it SHALL NOT drop until the corresponding output transfer occurs.

Reset
REQ-026 While rst=0, the following SHALL hold: dest_tvalid=0, src_tready=0, buffer empty, counter=0, dest_tlast=0, dest_tdata=0.
REQ-027 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-028 Reset assertion in the middle of a word SHALL discard the remaining beats.
REQ-029 On the first clock after rst returns to 1, src_tready SHALL be 1.

Structure
REQ-030 No shared package SHALL be used; the beat-counter width SHALL be a localparam equal to $clog2(NUM_PACK).
REQ-031 The block SHALL be a single module with no sub-modules; the slice mux SHALL be generate/array based.

Verification
REQ-032 Slice order, BIG_ENDIAN=1: src_tdata=0xA1B2C3D4, src_tlast=1, dest_tready=1 -> beats A1,B2,C3,D4 on four consecutive cycles, dest_tlast=1 on each beat.
REQ-033 Slice order, BIG_ENDIAN=0: same word -> beats D4,C3,B2,A1.
REQ-034 Back-to-back: words 0x01020304 then 0x05060708 (tlast=0) with src_tvalid held at 1 -> 8 gapless beats 01..08, src_tready=1 only in cycles where the final beat transfers.
REQ-035 Backpressure: drop dest_tready for 3 cycles after beat 1 -> dest_tdata is held stable, no beat is lost or duplicated, and src_tready=0 throughout.
REQ-036 Reset: assert rst=0 after beat 2 -> dest_tvalid=0 immediately; after release, a new word 0x11223344 yields 11,22,33,44.
REQ-037 Properties: the counter stays within 0..NUM_PACK-1, and every output transfer matches the captured word slice and captured tlast per REQ-017 and REQ-018.
